// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared definitions for the FIFO write arbiter: FSM state encoding, burst
// counter width and a small wrap-around increment helper.
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

    // FSM state encoding, kept as plain localparams so checkers can bind to
    // the raw values as well as to the enum.
    localparam logic STATE_IDLE  = 1'b0;
    localparam logic STATE_GRANT = 1'b1;

    // Burst counter width; wide enough for MAXBURST up to 255 without wrap.
    localparam int CNT_W = 8;

    typedef enum logic {
        ST_IDLE  = STATE_IDLE,
        ST_GRANT = STATE_GRANT
    } arb_state_t;

    // (v + 1) mod n, for round-robin pointer advance.
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage : fifo_arb_pkg

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin selector. Returns the first set bit of
// i_req found by searching upward from i_ptr, wrapping past N-1 back to 0.
//
// Ports
//   i_req  [N-1:0]   request vector
//   i_ptr  [IW-1:0]  search start position
//   o_idx  [IW-1:0]  selected index (equals i_ptr when nothing is requested)
//   o_any            at least one request bit is set
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    // One extra bit so ptr + offset never overflows before the wrap.
    logic [IW:0] w_sum;

    // Scan offsets from the far end down to 0 so the smallest offset from
    // i_ptr is the last (winning) assignment.
    always_comb begin
        o_idx = i_ptr;
        w_sum = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_ptr} + (IW + 1)'(k);
            if (w_sum >= (IW + 1)'(N)) begin
                w_sum = w_sum - (IW + 1)'(N);
            end
            if (i_req[w_sum[IW-1:0]]) begin
                o_idx = w_sum[IW-1:0];
            end
        end
    end

    assign o_any = |i_req;

endmodule : rr_pick

// File: rtl/fifo_wr_arb.sv
// -----------------------------------------------------------------------------
// fifo_wr_arb
// Round-robin arbiter that lets NREQ requesters write bursts of up to MAXBURST
// words into one downstream FIFO write port.
//
// Handshake: a requester word moves when REQ_VALID[i] && REQ_READY[i] at a
// rising edge of CLK. REQ_READY[i] is only ever high for the granted
// requester while the FIFO is not full, and FIFO_WE is high in exactly the
// cycles where that handshake completes, so every accepted word is written.
//
// Ports
//   CLK, RST                       clock, synchronous active-high reset
//   REQ_VALID [NREQ-1:0]           per-requester word available
//   REQ_DATA  [NREQ*DWIDTH-1:0]    word i at [i*DWIDTH +: DWIDTH]
//   REQ_READY [NREQ-1:0]           per-requester word accepted
//   FIFO_FULL                      downstream FIFO full
//   FIFO_WE, FIFO_DIN [DWIDTH-1:0] downstream FIFO write port
//   GNT_ID    [clog2(NREQ)-1:0]    current / last granted requester
//   BUSY                           FSM is in GRANT (also exposes FSM state)
// -----------------------------------------------------------------------------
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DWIDTH   = 32,
    parameter int MAXBURST = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NREQ-1:0]          REQ_VALID,
    input  logic [NREQ*DWIDTH-1:0]   REQ_DATA,
    output logic [NREQ-1:0]          REQ_READY,
    input  logic                     FIFO_FULL,
    output logic                     FIFO_WE,
    output logic [DWIDTH-1:0]        FIFO_DIN,
    output logic [$clog2(NREQ)-1:0]  GNT_ID,
    output logic                     BUSY
);

    localparam int IW = $clog2(NREQ);

    arb_state_t        r_state;
    logic [IW-1:0]     r_ptr;
    logic [IW-1:0]     r_gnt_id;
    logic [CNT_W-1:0]  r_cnt;

    logic [IW-1:0]     w_pick_idx;
    logic              w_pick_any;
    logic              w_in_grant;
    logic              w_gnt_valid;
    logic              w_xfer;
    logic              w_last_word;
    logic [IW-1:0]     w_next_ptr;

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr_pick (
        .i_req (REQ_VALID),
        .i_ptr (r_ptr),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    // Outputs are forced quiet while RST is high so a reset arriving
    // mid-burst cannot complete one more write in the reset cycle.
    assign w_in_grant  = (r_state == ST_GRANT) && !RST;
    assign w_gnt_valid = REQ_VALID[r_gnt_id];
    assign w_xfer      = w_in_grant && w_gnt_valid && !FIFO_FULL;
    assign w_last_word = (r_cnt == CNT_W'(MAXBURST - 1));
    assign w_next_ptr  = IW'(wrap_inc(int'(r_gnt_id), NREQ));

    always_comb begin
        REQ_READY = '0;
        if (w_in_grant) begin
            REQ_READY[r_gnt_id] = !FIFO_FULL;
        end
    end

    assign FIFO_WE  = w_xfer;
    assign FIFO_DIN = REQ_DATA[r_gnt_id*DWIDTH +: DWIDTH];
    assign GNT_ID   = r_gnt_id;
    assign BUSY     = w_in_grant;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_gnt_id <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        r_gnt_id <= w_pick_idx;
                        r_cnt    <= '0;
                        r_state  <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!w_gnt_valid) begin
                        // Requester ran dry: release without a transfer.
                        r_state <= ST_IDLE;
                        r_ptr   <= w_next_ptr;
                    end else if (!FIFO_FULL) begin
                        // Only real transfers count; full-stall cycles hold.
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last_word) begin
                            r_state <= ST_IDLE;
                            r_ptr   <= w_next_ptr;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : fifo_wr_arb

// File: tb/tb_fifo_wr_arb.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arb
// Directed scenarios followed by a randomized phase, all checked against a
// transaction-level reference model of the arbiter kept in this bench.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arb;

    localparam int NREQ     = 4;
    localparam int DWIDTH   = 32;
    localparam int MAXBURST = 4;
    localparam int IW       = 2;

    // ---------------- clock / reset ----------------
    logic                    CLK = 1'b0;
    logic                    RST;
    logic [NREQ-1:0]         REQ_VALID;
    logic [NREQ*DWIDTH-1:0]  REQ_DATA;
    logic [NREQ-1:0]         REQ_READY;
    logic                    FIFO_FULL;
    logic                    FIFO_WE;
    logic [DWIDTH-1:0]       FIFO_DIN;
    logic [IW-1:0]           GNT_ID;
    logic                    BUSY;

    always #5 CLK = ~CLK;

    fifo_wr_arb #(
        .NREQ     (NREQ),
        .DWIDTH   (DWIDTH),
        .MAXBURST (MAXBURST)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_VALID (REQ_VALID),
        .REQ_DATA  (REQ_DATA),
        .REQ_READY (REQ_READY),
        .FIFO_FULL (FIFO_FULL),
        .FIFO_WE   (FIFO_WE),
        .FIFO_DIN  (FIFO_DIN),
        .GNT_ID    (GNT_ID),
        .BUSY      (BUSY)
    );

    // ---------------- counters / scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [DWIDTH-1:0] exp_q[$];

    // ---------------- reference model ----------------
    // Model state: is some requester holding the grant, who, how many words
    // it has moved in this grant, and where the next search starts.
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_cnt   = 0;
    int m_ptr   = 0;
    int src_left[NREQ];
    int src_seq[NREQ];
    int m_wr[NREQ];

    // Observation bookkeeping from DUT outputs (grant order, burst lengths).
    logic prev_busy = 1'b0;
    int   cur_burst = 0;
    int   n_we_obs  = 0;
    int   obs_gnt[$];
    int   obs_burst[$];

    function automatic logic [DWIDTH-1:0] word_of(input int id, input int seq);
        logic [DWIDTH-1:0] w;
        w = DWIDTH'(id) << 24;
        w = w | DWIDTH'(seq & 32'h00FF_FFFF);
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_q(input string tag, input int got[$], input int exp[$]);
        check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check(tag, 32'(got[i]), 32'(exp[i]));
        end
    endtask

    task automatic clear_obs();
        obs_gnt.delete();
        obs_burst.delete();
        cur_burst = 0;
        n_we_obs  = 0;
        for (int i = 0; i < NREQ; i++) m_wr[i] = 0;
    endtask

    // ---------------- driver: one clock cycle ----------------
    // Called at a falling edge: drives inputs, checks outputs, then advances
    // the reference model across the rising edge.
    task automatic tick(input logic [NREQ-1:0] vmask, input logic full, input logic rst);
        logic [NREQ-1:0]   v;
        logic [NREQ-1:0]   exp_rdy;
        logic              exp_we;
        logic              exp_busy;
        logic [DWIDTH-1:0] w;
        bit                found;
        for (int i = 0; i < NREQ; i++) begin
            v[i] = vmask[i] && (src_left[i] > 0);
            REQ_DATA[i*DWIDTH +: DWIDTH] = word_of(i, src_seq[i]);
        end
        REQ_VALID = v;
        FIFO_FULL = full;
        RST       = rst;

        exp_busy = !rst && m_busy;
        exp_we   = exp_busy && v[m_owner] && !full;
        exp_rdy  = '0;
        if (exp_busy && !full) exp_rdy[m_owner] = 1'b1;
        if (exp_we) exp_q.push_back(word_of(m_owner, src_seq[m_owner]));

        #1;
        check("busy",  32'(BUSY),      32'(exp_busy));
        check("we",    32'(FIFO_WE),   32'(exp_we));
        check("ready", 32'(REQ_READY), 32'(exp_rdy));
        check("gnt",   32'(GNT_ID),    32'(m_owner));
        if (exp_we) begin
            w = exp_q.pop_front();
            if (FIFO_WE === 1'b1) check("din", FIFO_DIN, w);
        end

        if (BUSY === 1'b1 && prev_busy !== 1'b1) obs_gnt.push_back(int'(GNT_ID));
        if (FIFO_WE === 1'b1) begin
            n_we_obs++;
            cur_burst++;
        end
        if (prev_busy === 1'b1 && BUSY !== 1'b1) begin
            obs_burst.push_back(cur_burst);
            cur_burst = 0;
        end
        prev_busy = BUSY;

        @(posedge CLK);
        if (rst) begin
            m_busy = 1'b0; m_ptr = 0; m_owner = 0; m_cnt = 0;
        end else if (!m_busy) begin
            if (v != '0) begin
                found = 1'b0;
                for (int k = 0; k < NREQ; k++) begin
                    if (!found && v[(m_ptr + k) % NREQ]) begin
                        m_owner = (m_ptr + k) % NREQ;
                        found   = 1'b1;
                    end
                end
                m_cnt  = 0;
                m_busy = 1'b1;
            end
        end else if (!v[m_owner]) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % NREQ;
        end else if (!full) begin
            src_left[m_owner]--;
            src_seq[m_owner]++;
            m_wr[m_owner]++;
            m_cnt++;
            if (m_cnt == MAXBURST) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % NREQ;
            end
        end
        @(negedge CLK);
    endtask

    // Bounded wait on the model reaching n words from requester r.
    task automatic wait_wr(input int r, input int n);
        int k = 0;
        while (m_wr[r] < n && k < 50) begin
            tick('1, 1'b0, 1'b0);
            k++;
        end
        check("wait_bound", 32'(m_wr[r] >= n), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int exp_b[$];
        int exp_g[$];
        int we_before;
        for (int i = 0; i < NREQ; i++) begin
            src_left[i] = 0; src_seq[i] = 0; m_wr[i] = 0;
        end
        RST = 1'b1; REQ_VALID = '0; REQ_DATA = '0; FIFO_FULL = 1'b0;
        @(posedge CLK);
        @(negedge CLK);

        // Reset state, with requests already pending.
        src_left[1] = 1;
        tick('1, 1'b0, 1'b1);
        tick('1, 1'b0, 1'b1);
        src_left[1] = 0;

        // Only requester 2, ten words: bursts 4,4,2.
        clear_obs();
        src_left[2] = 10;
        repeat (16) tick('1, 1'b0, 1'b0);
        exp_b = '{4, 4, 2};
        exp_g = '{2, 2, 2};
        check_q("s1_burst", obs_burst, exp_b);
        check_q("s1_gnt", obs_gnt, exp_g);
        check("s1_writes", 32'(n_we_obs), 32'd10);

        // All four valid continuously: order 0,1,2,3,0, bursts of 4.
        tick('0, 1'b0, 1'b1);
        clear_obs();
        for (int i = 0; i < NREQ; i++) src_left[i] = 100;
        repeat (26) tick('1, 1'b0, 1'b0);
        exp_b = '{4, 4, 4, 4, 4};
        exp_g = '{0, 1, 2, 3, 0};
        check_q("s2_burst", obs_burst, exp_b);
        check_q("s2_gnt", obs_gnt, exp_g);
        for (int i = 0; i < NREQ; i++) src_left[i] = 0;
        repeat (3) tick('1, 1'b0, 1'b0);

        // Requester 1 with a 5-cycle FIFO_FULL stall after word 2.
        tick('0, 1'b0, 1'b1);
        clear_obs();
        src_left[1] = 4;
        wait_wr(1, 2);
        we_before = n_we_obs;
        repeat (5) tick('1, 1'b1, 1'b0);
        check("s3_stall_we", 32'(n_we_obs - we_before), 32'd0);
        repeat (4) tick('1, 1'b0, 1'b0);
        check("s3_writes", 32'(n_we_obs), 32'd4);
        exp_b = '{4};
        check_q("s3_burst", obs_burst, exp_b);

        // Requester 0 drops after 2 words; pointer then favours 3 over 0.
        tick('0, 1'b0, 1'b1);
        clear_obs();
        src_left[0] = 2;
        repeat (6) tick('1, 1'b0, 1'b0);
        src_left[0] = 1;
        src_left[3] = 1;
        repeat (8) tick('1, 1'b0, 1'b0);
        exp_g = '{0, 3, 0};
        check_q("s4_gnt", obs_gnt, exp_g);

        // Reset mid-burst from requester 3; afterwards 0 wins over 3.
        tick('0, 1'b0, 1'b1);
        clear_obs();
        src_left[3] = 10;
        wait_wr(3, 2);
        we_before = n_we_obs;
        tick('1, 1'b0, 1'b1);
        check("s5_rst_we", 32'(n_we_obs - we_before), 32'd0);
        clear_obs();
        src_left[0] = 3;
        repeat (3) tick('1, 1'b0, 1'b0);
        check("s5_first_gnt", 32'(obs_gnt.size() > 0 ? obs_gnt[0] : -1), 32'd0);

        // Randomized phase.
        tick('0, 1'b0, 1'b1);
        for (int i = 0; i < NREQ; i++) src_left[i] = 0;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (src_left[i] == 0 && $urandom_range(0, 3) == 0)
                    src_left[i] = $urandom_range(1, 9);
            end
            tick(NREQ'($urandom_range(0, 15) | ($urandom_range(0, 1) ? 15 : 0)),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 99) == 0));
        end

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_fifo_wr_arb

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL provide parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL provide parameter DWIDTH, default 32, data word width.
REQ-003 SHALL provide parameter MAXBURST, default 4, maximum words per grant (1..255).
REQ-004 SHALL provide port CLK  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL provide port RST  input  1  reset, synchronous and active-high.
REQ-006 SHALL provide port REQ_VALID  input  NREQ  bit i: requester i has a word.
REQ-007 SHALL provide port REQ_DATA  input  NREQ*DWIDTH  word i at bits [i*DWIDTH +: DWIDTH].
REQ-008 SHALL provide port REQ_READY  output  NREQ  bit i: word i accepted this cycle when REQ_VALID[i] is also high.
REQ-009 SHALL provide port FIFO_FULL  input  1  full flag of the downstream FIFO write side.
REQ-010 SHALL provide port FIFO_WE  output  1  write enable to the FIFO.
REQ-011 SHALL provide port FIFO_DIN  output  DWIDTH  write data to the FIFO.
REQ-012 SHALL provide port GNT_ID  output  clog2(NREQ)  index of the current or last granted requester.
REQ-013 SHALL provide port BUSY  output  1  high while in state GRANT.

Function
REQ-014 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-015 In IDLE with any REQ_VALID high, SHALL select the first valid requester searching upward (with wrap) from round-robin pointer PTR, register it into GNT_ID, clear the burst counter, and enter GRANT next cycle.
REQ-016 In IDLE, SHALL hold REQ_READY all-zero and FIFO_WE low (one arbitration cycle per grant).
REQ-017 In GRANT, REQ_READY[GNT_ID] SHALL equal !FIFO_FULL, combinationally; all other REQ_READY bits SHALL be 0.
REQ-018 A transfer occurs when in GRANT and REQ_VALID[GNT_ID] && !FIFO_FULL; FIFO_WE SHALL be high in exactly that cycle (zero latency, combinational).
REQ-019 FIFO_DIN SHALL equal the REQ_DATA slice of GNT_ID whenever FIFO_WE is high; its value is don't-care otherwise.
REQ-020 The burst counter SHALL increment by 1 per transfer only; FIFO_FULL stall cycles SHALL NOT count.
REQ-021 SHALL leave GRANT for IDLE after the cycle in which the transfer brings the counter to MAXBURST.
REQ-022 SHALL leave GRANT for IDLE in any cycle where REQ_VALID[GNT_ID] is low (no transfer that cycle).
REQ-023 A stall (valid high, FIFO_FULL high) SHALL keep GRANT indefinitely with counter unchanged.
REQ-024 On every GRANT->IDLE transition, PTR SHALL become (GNT_ID+1) mod NREQ.
REQ-025 REQ_VALID changes on non-granted requesters during GRANT SHALL have no effect.
REQ-026 GNT_ID SHALL retain its value in IDLE until the next selection.
REQ-027 The counter SHALL be wide enough for MAXBURST without wrap (8 bits).

Reset
REQ-028 With RST high at a rising edge, SHALL enter IDLE, set PTR=0, counter=0, GNT_ID=0.
REQ-029 During and after reset until the next grant: BUSY=0, FIFO_WE=0, REQ_READY=0.
REQ-030 Reset mid-burst SHALL abort the grant with no further FIFO_WE; PTR SHALL restart at 0, not advance.

Structure
REQ-031 FSM state encoding (IDLE=0, GRANT=1) and counter width SHALL be localparams in shared package fifo_arb_pkg.
REQ-032 Round-robin selection SHALL be sub-module rr_pick (inputs: request vector, PTR; outputs: index, any-valid), purely combinational.
REQ-033 All state SHALL be in one clocked process; REQ_READY/FIFO_WE/FIFO_DIN are combinational from state and inputs.

Verification
REQ-034 Only requester 2 valid for 10 words, MAXBURST=4, FIFO_FULL=0 -> bursts of 4,4,2 FIFO_WE pulses, each preceded by one IDLE cycle, GNT_ID=2 throughout.
REQ-035 All four valid continuously, MAXBURST=4 -> grant order 0,1,2,3,0; each burst exactly 4 writes; data written in order.
REQ-036 Requester 1 granted, FIFO_FULL high for 5 cycles after 2nd word -> FIFO_WE low 5 cycles, BUSY high, then words 3-4 written; total 4.
REQ-037 Requester 0 drops valid after word 2 -> GRANT exits next cycle, PTR=1; requester 3 valid later -> granted, GNT_ID=3.
REQ-038 RST pulsed after word 2 of a burst from requester 3 -> no further FIFO_WE; after release with requesters 0 and 3 valid, requester 0 is granted first.
